mimo_nibble_packer: RTL

- Downstream of the MIMO-OFDM receiver top. Consumes the three per-cycle 4-bit 16-QAM demapped symbols (output_num0/1/2, qualified by output_valid).
- Packs eight symbols per stream into 32-bit words and buffers completed word-triples in a small FIFO.
- Emits words one beat at a time over a valid/ready interface to the host/DMA side, in stream order 0, 1, 2.

---
 rtl/mimo_nibble_packer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mimo_nibble_packer.sv
// Packs per-cycle 4-bit symbols from three streams into 32-bit words, buffers
// completed word-triples in a FIFO and streams them out as stream 0, 1, 2 beats.
module mimo_nibble_packer #(
  parameter int NIBS_PER_WORD = 8,
  parameter int FIFO_DEPTH    = 4,
  localparam int W  = 4 * NIBS_PER_WORD,
  localparam int CW = $clog2(NIBS_PER_WORD),
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int LW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [3:0]    in_num0,
  input  logic [3:0]    in_num1,
  input  logic [3:0]    in_num2,
  input  logic          in_flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [1:0]    out_stream,
  output logic          out_last,
  output logic [LW-1:0] fifo_level,
  output logic          overflow
);

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready is low the beat is held unchanged.

  typedef struct packed {
    logic         last;
    logic [W-1:0] w2;
    logic [W-1:0] w1;
    logic [W-1:0] w0;
  } triple_t;

  localparam logic [CW-1:0] LAST_NIB = CW'(NIBS_PER_WORD - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic [CW-1:0] cnt;
  logic [W-1:0]  acc0, acc1, acc2;
  logic [W-1:0]  ins0, ins1, ins2;
  logic          push, push_ok, pop, load;
  triple_t       push_entry;

  triple_t       mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;

  logic          st_valid;
  logic [1:0]    beat;
  triple_t       st;

  // Accumulators with this cycle's nibble inserted; unused slots stay zero,
  // which gives the flush padding for free.
  always_comb begin
    ins0 = acc0;
    ins1 = acc1;
    ins2 = acc2;
    if (in_valid) begin
      ins0[{cnt, 2'b00} +: 4] = in_num0;
      ins1[{cnt, 2'b00} +: 4] = in_num1;
      ins2[{cnt, 2'b00} +: 4] = in_num2;
    end
    push       = (in_valid && cnt == LAST_NIB) || (in_flush && (in_valid || cnt != '0));
    push_entry = '{last: in_flush, w2: ins2, w1: ins1, w0: ins0};
    load       = !st_valid || (out_ready && beat == 2'd2);
    pop        = load && level != '0;
    push_ok    = push && (level != FULL_LVL || pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      acc0 <= '0;
      acc1 <= '0;
      acc2 <= '0;
    end else if (push) begin
      cnt  <= '0;
      acc0 <= '0;
      acc1 <= '0;
      acc2 <= '0;
    end else if (in_valid) begin
      cnt  <= cnt + 1'b1;
      acc0 <= ins0;
      acc1 <= ins1;
      acc2 <= ins2;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push_ok) - LW'(pop);
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  // Output stage: reloads from the FIFO on the beat-2 handshake edge, no bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_valid <= 1'b0;
      beat     <= '0;
      st       <= '0;
    end else if (pop) begin
      st_valid <= 1'b1;
      beat     <= '0;
      st       <= mem[rd_ptr];
    end else if (st_valid && out_ready) begin
      if (beat == 2'd2) st_valid <= 1'b0;
      else              beat     <= beat + 1'b1;
    end
  end

  always_comb begin
    out_data = st.w0;
    case (beat)
      2'd1:    out_data = st.w1;
      2'd2:    out_data = st.w2;
      default: out_data = st.w0;
    endcase
    out_valid  = st_valid;
    out_stream = beat;
    out_last   = st.last && beat == 2'd2;
    fifo_level = level;
  end

endmodule
